iter_shifter: RTL



---
 rtl/iter_shifter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle WIDTH-bit shifter with valid/ready handshakes on both sides.
// Modes (in_op): 00 LSL, 01 LSR, 10 ASR (sign fill), 11 ROR. Up to STEP positions per BUSY cycle.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   in_valid/in_ready            request handshake; in_data, in_op, in_amt sampled on accept
//   out_valid/out_ready          result handshake; out_data, out_carry, out_zero held until taken
module iter_shifter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = 5,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 2);
    // Shifting WIDTH+1 times fully flushes the word and leaves the fill bit in carry.
    localparam int unsigned SAT   = WIDTH + 1;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_data;
    logic [1:0]         r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_zero;
    logic               r_out_valid;
    logic               r_in_ready;

    logic [31:0]        w_amt32;
    logic [CNT_W-1:0]   w_load_cnt;
    logic [WIDTH-1:0]   w_data;
    logic               w_carry;
    logic [CNT_W-1:0]   w_cnt_next;

    // Remaining count at accept: saturating for shifts, modulo WIDTH for rotate.
    always_comb begin
        w_amt32 = 32'(in_amt);
        if (in_op == 2'b11) begin
            w_load_cnt = CNT_W'(w_amt32 % WIDTH);
        end else if (w_amt32 > SAT) begin
            w_load_cnt = CNT_W'(SAT);
        end else begin
            w_load_cnt = CNT_W'(w_amt32);
        end
    end

    // One BUSY cycle: min(STEP, r_cnt) single-position stages; carry ends on the last bit out.
    always_comb begin
        w_data  = r_data;
        w_carry = r_carry;
        for (int unsigned i = 0; i < STEP; i++) begin
            if (i < 32'(r_cnt)) begin
                case (r_op)
                    OP_LSL: begin
                        w_carry = w_data[WIDTH-1];
                        w_data  = {w_data[WIDTH-2:0], 1'b0};
                    end
                    OP_LSR: begin
                        w_carry = w_data[0];
                        w_data  = {1'b0, w_data[WIDTH-1:1]};
                    end
                    OP_ASR: begin
                        w_carry = w_data[0];
                        w_data  = {w_data[WIDTH-1], w_data[WIDTH-1:1]};
                    end
                    default: begin
                        w_carry = w_data[0];
                        w_data  = {w_data[0], w_data[WIDTH-1:1]};
                    end
                endcase
            end
        end
        if (32'(r_cnt) > STEP) begin
            w_cnt_next = r_cnt - CNT_W'(STEP);
        end else begin
            w_cnt_next = '0;
        end
    end

    // Control FSM and datapath registers.
    // DONE spends one cycle computing out_zero before raising out_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_op        <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_data     <= in_data;
                        r_op       <= in_op;
                        r_cnt      <= w_load_cnt;
                        r_carry    <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= (w_load_cnt != '0) ? BUSY : DONE;
                    end
                end
                BUSY: begin
                    r_data  <= w_data;
                    r_carry <= w_carry;
                    r_cnt   <= w_cnt_next;
                    if (w_cnt_next == '0) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_zero      <= (r_data == '0);
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_data;
    assign out_carry = r_carry;
    assign out_zero  = r_zero;

endmodule
